// File: rtl/fp_pkg.sv
// Shared constants and types for the 13-bit fp word format {sign, exp[3:0], man[7:0]}.
// Value of a word is (-1)^sign * 0.man * 2^exp with an unbiased exponent.
package fp_pkg;

    localparam int FP_W     = 13;
    localparam int EXP_W    = 4;
    localparam int MAN_W    = 8;

    localparam int SIGN_BIT = FP_W - 1;
    localparam int EXP_MSB  = FP_W - 2;
    localparam int EXP_LSB  = MAN_W;
    localparam int MAN_MSB  = MAN_W - 1;

    localparam logic [FP_W-1:0] FP_ZERO    = '0;
    localparam logic [FP_W-1:0] FP_SAT_NEG = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } enc_state_t;

endpackage

// File: rtl/fp_int_encoder.sv
// Iterative signed-integer to fp-word encoder: one normalising left shift per cycle,
// valid/ready handshake on input and output.
module fp_int_encoder
    import fp_pkg::*;
#(
    parameter int INT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [INT_W-1:0] i_int,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [FP_W-1:0]  o_fp,
    output logic             o_ovf
);

    localparam int MAG_W = INT_W - 1;
    localparam logic [MAG_W-1:0] MAG_ONE = MAG_W'(1);
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
    localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    enc_state_t       state_reg, state_next;
    logic [MAG_W-1:0] mag_reg, mag_next;
    logic [EXP_W-1:0] exp_reg, exp_next;
    logic             sign_reg, sign_next;
    logic [FP_W-1:0]  fp_reg, fp_next;
    logic             ovf_reg, ovf_next;

    // Low bits of |i_int| are exact for every input except INT_MIN, which saturates.
    logic [MAG_W-1:0] abs_low;
    assign abs_low = i_int[INT_W-1] ? (~i_int[MAG_W-1:0] + MAG_ONE) : i_int[MAG_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            mag_reg   <= '0;
            exp_reg   <= '0;
            sign_reg  <= 1'b0;
            fp_reg    <= FP_ZERO;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mag_reg   <= mag_next;
            exp_reg   <= exp_next;
            sign_reg  <= sign_next;
            fp_reg    <= fp_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mag_next   = mag_reg;
        exp_next   = exp_reg;
        sign_next  = sign_reg;
        fp_next    = fp_reg;
        ovf_next   = ovf_reg;

        unique case (state_reg)
            IDLE: begin
                if (i_valid) begin
                    sign_next = i_int[INT_W-1];
                    mag_next  = abs_low;
                    exp_next  = '1;
                    if (i_int == '0) begin
                        fp_next    = FP_ZERO;
                        ovf_next   = 1'b0;
                        state_next = DONE;
                    end else if (i_int == INT_MIN) begin
                        fp_next    = FP_SAT_NEG;
                        ovf_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        ovf_next   = 1'b0;
                        state_next = NORM;
                    end
                end
            end
            NORM: begin
                // Magnitude is non-zero here, so the exponent cannot underflow.
                if (mag_reg[MAG_W-1]) begin
                    fp_next[SIGN_BIT]        = sign_reg;
                    fp_next[EXP_MSB:EXP_LSB] = exp_reg;
                    fp_next[MAN_MSB:0]       = mag_reg[MAG_W-1 -: MAN_W];
                    state_next               = DONE;
                end else begin
                    mag_next = mag_reg << 1;
                    exp_next = exp_reg - EXP_ONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_ready = (state_reg == IDLE);
    assign o_valid = (state_reg == DONE);
    assign o_fp    = fp_reg;
    assign o_ovf   = ovf_reg;

endmodule

// File: tb/tb_fp_int_encoder.sv
// Bench for fp_int_encoder: directed and randomized words checked every cycle
// against an arithmetic reference model.
module tb_fp_int_encoder;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_int;
    logic        o_valid;
    logic        i_ready;
    logic [12:0] o_fp;
    logic        o_ovf;

    int checks = 0;
    int errors = 0;

    fp_int_encoder #(.INT_W(16)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_int   (i_int),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_fp    (o_fp),
        .o_ovf   (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no response within cycle budget (t=%0t)", name, $time);
    endtask

    // Reference: value = 0.man * 2^exp, so exp is the bit length of |x| and
    // man = floor(|x| * 2^8 / 2^exp). Latency counts the accept edge.
    function automatic void model(input logic [15:0] x, output logic [12:0] fp,
                                  output logic ovf, output int lat);
        int v, m, e;
        v = $signed(x);
        if (v == 0) begin
            fp = 13'd0; ovf = 1'b0; lat = 1;
        end else if (v == -32768) begin
            fp = 13'h1FFF; ovf = 1'b1; lat = 1;
        end else begin
            m   = (v < 0) ? -v : v;
            e   = $clog2(m + 1);
            fp  = {v < 0, 4'(e), 8'((m * 256) >> e)};
            ovf = 1'b0;
            lat = 2 + (15 - e);
        end
    endfunction

    // Cycle-level compare process; inputs change only #1 after posedge, so values
    // seen at negedge are what the next posedge samples.
    bit          m_busy = 1'b0;
    int          m_cnt  = 0;
    int          m_lat  = 0;
    logic [12:0] m_fp   = '0;
    logic        m_ovf  = 1'b0;
    bit          m_ev;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            chk("rst_valid", 32'(o_valid), 32'(0));
            chk("rst_fp",    32'(o_fp),    32'(0));
            chk("rst_ovf",   32'(o_ovf),   32'(0));
            m_busy = 1'b0;
        end else begin
            if (m_busy) m_cnt++;
            m_ev = m_busy && (m_cnt >= m_lat);
            chk("valid", 32'(o_valid), 32'(m_ev));
            chk("ready", 32'(o_ready), 32'(!m_busy));
            if (m_ev) begin
                chk("fp",  32'(o_fp),  32'(m_fp));
                chk("ovf", 32'(o_ovf), 32'(m_ovf));
            end
            if (m_ev && i_ready) begin
                m_busy = 1'b0;
            end else if (!m_busy && i_valid) begin
                model(i_int, m_fp, m_ovf, m_lat);
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
    end

    int word_no = 0;

    task automatic send(input logic [15:0] x, input int bp,
                        output logic [12:0] fp, output logic ovf, output int lat);
        int n;
        i_int   = x;
        i_valid = 1'b1;
        i_ready = (bp == 0);
        n = 0;
        while (1) begin
            @(negedge i_clk);
            if (o_ready) break;
            n++;
            if (n > 50) begin timeout_fail("accept_timeout"); break; end
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (1) begin
            @(negedge i_clk);
            lat++;
            if (o_valid) break;
            if (lat >= 40) begin timeout_fail("valid_timeout"); break; end
            // Noise on the input side while busy must be ignored.
            @(posedge i_clk); #1;
            i_valid = 1'($urandom_range(0, 1));
            i_int   = 16'($urandom);
        end
        fp  = o_fp;
        ovf = o_ovf;
        if (bp > 0) begin
            repeat (bp) @(posedge i_clk);
            #1;
            i_ready = 1'b1;
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        $display("word %0d: in=%0d fp=%b ovf=%0b lat=%0d bp=%0d",
                 word_no, $signed(x), fp, ovf, lat, bp);
        word_no++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [12:0] r_fp;
    logic        r_ovf;
    int          r_lat;
    logic [12:0] p_fp;
    logic        p_ovf;
    int          p_lat;
    logic [15:0] rx;

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_int   = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("ready_after_reset", 32'(o_ready), 32'(1));

        // Pin the reference model against hand-computed words.
        model(16'd300, p_fp, p_ovf, p_lat);
        chk("model_300_fp", 32'(p_fp), 32'(13'b0_1001_10010110));
        chk("model_300_lat", 32'(p_lat), 32'(8));
        model(16'hFFFF, p_fp, p_ovf, p_lat);
        chk("model_m1_fp", 32'(p_fp), 32'(13'b1_0001_10000000));
        chk("model_m1_lat", 32'(p_lat), 32'(16));

        @(posedge i_clk); #1;
        send(16'd0, 0, r_fp, r_ovf, r_lat);
        chk("zero_fp", 32'(r_fp), 32'(13'b0_0000_00000000));
        chk("zero_ovf", 32'(r_ovf), 32'(0));
        chk("zero_lat", 32'(r_lat), 32'(1));

        send(16'd1, 0, r_fp, r_ovf, r_lat);
        chk("p1_fp", 32'(r_fp), 32'(13'b0_0001_10000000));
        chk("p1_lat", 32'(r_lat), 32'(16));

        send(16'hFFFF, 1, r_fp, r_ovf, r_lat);
        chk("m1_fp", 32'(r_fp), 32'(13'b1_0001_10000000));
        chk("m1_lat", 32'(r_lat), 32'(16));

        send(16'd32767, 0, r_fp, r_ovf, r_lat);
        chk("max_fp", 32'(r_fp), 32'(13'b0_1111_11111111));
        chk("max_lat", 32'(r_lat), 32'(2));

        send(16'd300, 2, r_fp, r_ovf, r_lat);
        chk("p300_fp", 32'(r_fp), 32'(13'b0_1001_10010110));
        chk("p300_lat", 32'(r_lat), 32'(8));

        send(16'h8000, 3, r_fp, r_ovf, r_lat);
        chk("sat_fp", 32'(r_fp), 32'(13'b1_1111_11111111));
        chk("sat_ovf", 32'(r_ovf), 32'(1));
        chk("sat_lat", 32'(r_lat), 32'(1));

        // Reset in the middle of normalising +1.
        i_int   = 16'd1;
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(o_valid), 32'(0));
        chk("abort_fp", 32'(o_fp), 32'(0));
        chk("abort_ovf", 32'(o_ovf), 32'(0));
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        $display("reset applied mid-normalise");
        send(16'd2, 0, r_fp, r_ovf, r_lat);
        chk("p2_fp", 32'(r_fp), 32'(13'b0_0010_10000000));
        chk("p2_lat", 32'(r_lat), 32'(15));

        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 5))
                0:       rx = 16'd0;
                1:       rx = 16'h8000;
                2:       rx = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(1, 15))
                                                          : 16'(-$urandom_range(1, 15));
                default: rx = 16'($urandom);
            endcase
            send(rx, $urandom_range(0, 3), r_fp, r_ovf, r_lat);
        end

        repeat (3) @(posedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
